sched_ctrl: RTL and testbench

- Pipeline scheduler and interrupt controller for the 16-bit five-stage core.
- Consumes the control requests the decode stage emits: pause requests, INT/ERET, MTIH enable/disable.
- Drives IF/ID stall, ID/EX bubble and IF redirect.
- Owns the interrupt-enable bit, CAUSE and EPC. Returns CAUSE and the enable bit to decode so MFIH can read them.

---
 rtl/sched_ctrl_pkg.sv | 36 +++
 rtl/sched_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sched_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sched_ctrl_pkg.sv
// sched_ctrl_pkg: shared definitions for the pipeline scheduler / interrupt
// controller.
//   - schedule-type codes that decode places on sci_sched_type
//   - FSM state encoding
//   - CAUSE layout constant and the INT id reserved for ERET
//   - sched_ctl_t: the bundle of pipeline control outputs produced each cycle
//   - stall_len(): converts a requested stall count into a real cycle count
package sched_ctrl_pkg;

    localparam logic [3:0] SCHED_CONTINUE     = 4'h0;
    localparam logic [3:0] SCHED_PAUSE_FOR_LW = 4'h1;

    // Hardware-originated causes set this bit; software INT leaves it clear.
    localparam int         CAUSE_HW_BIT       = 7;
    localparam logic [3:0] INT_ID_ERET        = 4'hF;

    typedef enum logic [1:0] {
        SCHED_ST_RUN   = 2'd0,
        SCHED_ST_PAUSE = 2'd1,
        SCHED_ST_TRAP  = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic        stall;
        logic        bubble;
        logic        flush_id;
        logic        branch;
        logic [15:0] new_pc;
    } sched_ctl_t;

    // A requested count of 0 still costs one stall cycle.
    function automatic logic [3:0] stall_len(input logic [3:0] cnt);
        return (cnt == 4'd0) ? 4'd1 : cnt;
    endfunction

endpackage

// File: rtl/sched_ctrl.sv
// sched_ctrl: pipeline scheduler and interrupt controller for the 16-bit
// five-stage core.
//
// Ports
//   clk, rst                      core clock; asynchronous active-low reset
//   sci_pause_request/_type/_count stall request from decode
//   sci_int, sci_int_id           INT n (or ERET when id == ERET_ID)
//   sci_int_enable/_disable       MTIH set / clear of the interrupt-enable bit
//   sci_id_addr, sci_id_branch    PC of the ID instruction; decode redirecting
//   sci_ext_int, sci_ext_id       level external interrupt and its source id
//   sco_stall, sco_bubble         hold PC + IF/ID; NOP into ID/EX
//   sco_flush_id                  NOP into IF/ID
//   sco_branch, sco_new_pc        IF redirect and its target
//   sco_int_en, sco_cause, sco_epc architectural interrupt state for decode
//
// All control outputs are combinational from state, registers and inputs.
// While rst is low every output except sco_int_en is forced to zero.
module sched_ctrl
    import sched_ctrl_pkg::*;
#(
    parameter logic [15:0] HANDLER_ADDR = 16'h0008,
    parameter logic        INT_EN_RESET = 1'b1,
    parameter logic [3:0]  ERET_ID      = INT_ID_ERET
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sci_pause_request,
    input  logic [3:0]  sci_sched_type,
    input  logic [3:0]  sci_sched_count,
    input  logic        sci_int,
    input  logic [3:0]  sci_int_id,
    input  logic        sci_int_enable,
    input  logic        sci_int_disable,
    input  logic [15:0] sci_id_addr,
    input  logic        sci_id_branch,
    input  logic        sci_ext_int,
    input  logic [2:0]  sci_ext_id,
    output logic        sco_stall,
    output logic        sco_bubble,
    output logic        sco_flush_id,
    output logic        sco_branch,
    output logic [15:0] sco_new_pc,
    output logic        sco_int_en,
    output logic [7:0]  sco_cause,
    output logic [15:0] sco_epc
);

    sched_state_e state_q, state_d;
    logic [3:0]   rem_q, rem_d;
    logic         int_en_q, int_en_d;
    logic [7:0]   cause_q, cause_d;
    logic [15:0]  epc_q, epc_d;
    logic         pending_q, pending_d;
    logic [2:0]   id_src_q, id_src_d;
    logic [3:0]   n_len;
    logic         take_ext;
    sched_ctl_t   ctl;

    // Both schedule types stall identically; the type is informational.
    logic unused_sched_type;
    assign unused_sched_type = ^sci_sched_type;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SCHED_ST_RUN;
            rem_q     <= 4'd0;
            int_en_q  <= INT_EN_RESET;
            cause_q   <= 8'h00;
            epc_q     <= 16'h0000;
            pending_q <= 1'b0;
            id_src_q  <= 3'd0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            int_en_q  <= int_en_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            pending_q <= pending_d;
            id_src_q  <= id_src_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        int_en_d  = int_en_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        pending_d = pending_q;
        id_src_d  = id_src_q;
        ctl       = '0;
        take_ext  = 1'b0;
        n_len     = stall_len(sci_sched_count);

        unique case (state_q)
            SCHED_ST_RUN: begin
                if (sci_pause_request) begin
                    // This cycle is the first of N stall cycles.
                    ctl.stall  = 1'b1;
                    ctl.bubble = 1'b1;
                    if (n_len > 4'd1) begin
                        rem_d   = n_len - 4'd1;
                        state_d = SCHED_ST_PAUSE;
                    end
                end else if (sci_int && sci_int_id == ERET_ID) begin
                    ctl.branch   = 1'b1;
                    ctl.new_pc   = epc_q;
                    ctl.flush_id = 1'b1;
                    int_en_d     = 1'b1;
                    state_d      = SCHED_ST_TRAP;
                end else if (sci_int) begin
                    // Software INT returns past itself.
                    ctl.branch   = 1'b1;
                    ctl.new_pc   = HANDLER_ADDR;
                    ctl.flush_id = 1'b1;
                    epc_d        = sci_id_addr + 16'd1;
                    cause_d      = {4'h0, sci_int_id};
                    int_en_d     = 1'b0;
                    state_d      = SCHED_ST_TRAP;
                end else if (pending_q && int_en_q && !sci_id_branch) begin
                    // The ID instruction is squashed and re-executed on return,
                    // so EPC points at it rather than past it. A branching ID
                    // instruction defers entry since its target is not yet known.
                    ctl.branch   = 1'b1;
                    ctl.new_pc   = HANDLER_ADDR;
                    ctl.flush_id = 1'b1;
                    ctl.bubble   = 1'b1;
                    epc_d        = sci_id_addr;
                    cause_d      = 8'h00;
                    cause_d[CAUSE_HW_BIT] = 1'b1;
                    cause_d[2:0] = id_src_q;
                    int_en_d     = 1'b0;
                    take_ext     = 1'b1;
                    state_d      = SCHED_ST_TRAP;
                end else begin
                    if (sci_int_disable)     int_en_d = 1'b0;
                    else if (sci_int_enable) int_en_d = 1'b1;
                end
            end
            SCHED_ST_PAUSE: begin
                ctl.stall  = 1'b1;
                ctl.bubble = 1'b1;
                rem_d      = rem_q - 4'd1;
                if (rem_q <= 4'd1) state_d = SCHED_ST_RUN;
            end
            SCHED_ST_TRAP: begin
                // Guard cycle: lets the handler's first instruction reach ID
                // before anything can re-enter.
                ctl.flush_id = 1'b1;
                state_d      = SCHED_ST_RUN;
            end
            default: state_d = SCHED_ST_RUN;
        endcase

        // Taking the interrupt wins over a same-cycle re-latch; a still-high
        // level is picked up again on the next edge.
        if (take_ext) begin
            pending_d = 1'b0;
        end else if (sci_ext_int) begin
            pending_d = 1'b1;
            id_src_d  = sci_ext_id;
        end
    end

    assign sco_stall    = rst & ctl.stall;
    assign sco_bubble   = rst & ctl.bubble;
    assign sco_flush_id = rst & ctl.flush_id;
    assign sco_branch   = rst & ctl.branch;
    assign sco_new_pc   = rst ? ctl.new_pc : 16'h0000;
    assign sco_int_en   = int_en_q;
    assign sco_cause    = rst ? cause_q : 8'h00;
    assign sco_epc      = rst ? epc_q : 16'h0000;

endmodule

// File: tb/tb_sched_ctrl.sv
// tb_sched_ctrl: directed stimulus for sched_ctrl with a per-cycle reference
// model plus hand-computed literal expectations at key points.
module tb_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sci_pause_request = 1'b0;
    logic [3:0]  sci_sched_type = 4'h0;
    logic [3:0]  sci_sched_count = 4'h0;
    logic        sci_int = 1'b0;
    logic [3:0]  sci_int_id = 4'h0;
    logic        sci_int_enable = 1'b0;
    logic        sci_int_disable = 1'b0;
    logic [15:0] sci_id_addr = 16'h0000;
    logic        sci_id_branch = 1'b0;
    logic        sci_ext_int = 1'b0;
    logic [2:0]  sci_ext_id = 3'd0;
    logic        sco_stall, sco_bubble, sco_flush_id, sco_branch, sco_int_en;
    logic [15:0] sco_new_pc, sco_epc;
    logic [7:0]  sco_cause;

    sched_ctrl #(
        .HANDLER_ADDR(16'h0008),
        .INT_EN_RESET(1'b1),
        .ERET_ID     (4'hF)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sci_pause_request(sci_pause_request),
        .sci_sched_type   (sci_sched_type),
        .sci_sched_count  (sci_sched_count),
        .sci_int          (sci_int),
        .sci_int_id       (sci_int_id),
        .sci_int_enable   (sci_int_enable),
        .sci_int_disable  (sci_int_disable),
        .sci_id_addr      (sci_id_addr),
        .sci_id_branch    (sci_id_branch),
        .sci_ext_int      (sci_ext_int),
        .sci_ext_id       (sci_ext_id),
        .sco_stall        (sco_stall),
        .sco_bubble       (sco_bubble),
        .sco_flush_id     (sco_flush_id),
        .sco_branch       (sco_branch),
        .sco_new_pc       (sco_new_pc),
        .sco_int_en       (sco_int_en),
        .sco_cause        (sco_cause),
        .sco_epc          (sco_epc)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h @%0t", name, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model. Inputs are driven just after posedge, so at negedge
    // they are the values the next posedge samples: compare, then advance.
    // ---------------------------------------------------------------
    int          m_stall_left = 0;   // further stall cycles still owed
    bit          m_guard = 0;        // a one-cycle guard follows a redirect
    bit          m_int_en = 1;
    bit          m_pend = 0;
    logic [2:0]  m_src = 3'd0;
    logic [7:0]  m_cause = 8'h00;
    logic [15:0] m_epc = 16'h0000;

    always @(negedge clk) begin : model
        logic [3:0]  e_ctl;   // {stall, bubble, flush_id, branch}
        logic [15:0] e_pc;
        logic        r_int_en;
        logic [7:0]  r_cause;
        logic [15:0] r_epc;
        logic        took;
        logic [44:0] got;
        int          n;
        got = {sco_stall, sco_bubble, sco_flush_id, sco_branch, sco_new_pc,
               sco_int_en, sco_cause, sco_epc};
        e_ctl = 4'b0000;
        e_pc  = 16'h0000;
        took  = 1'b0;
        if (!rst) begin
            m_stall_left = 0; m_guard = 0; m_int_en = 1; m_pend = 0;
            m_src = 3'd0; m_cause = 8'h00; m_epc = 16'h0000;
            lit("model_reset_outputs", {19'd0, got}, {19'd0, 4'b0000, 16'h0000, 1'b1, 8'h00, 16'h0000});
        end else begin
            r_int_en = m_int_en; r_cause = m_cause; r_epc = m_epc;
            if (m_stall_left > 0) begin
                e_ctl = 4'b1100;
                m_stall_left--;
            end else if (m_guard) begin
                e_ctl = 4'b0010;
                m_guard = 0;
            end else if (sci_pause_request) begin
                n = (sci_sched_count == 0) ? 1 : int'(sci_sched_count);
                e_ctl = 4'b1100;
                m_stall_left = n - 1;
            end else if (sci_int && sci_int_id == 4'hF) begin
                e_ctl = 4'b0011; e_pc = m_epc;
                m_int_en = 1; m_guard = 1;
            end else if (sci_int) begin
                e_ctl = 4'b0011; e_pc = 16'h0008;
                m_epc = sci_id_addr + 16'd1;
                m_cause = 8'(sci_int_id);
                m_int_en = 0; m_guard = 1;
            end else if (m_pend && m_int_en && !sci_id_branch) begin
                e_ctl = 4'b0111; e_pc = 16'h0008;
                m_epc = sci_id_addr;
                m_cause = 8'h80 + 8'(m_src);
                m_int_en = 0; m_guard = 1; took = 1'b1;
            end else if (sci_int_disable) begin
                m_int_en = 0;
            end else if (sci_int_enable) begin
                m_int_en = 1;
            end
            if (took) m_pend = 0;
            else if (sci_ext_int) begin m_pend = 1; m_src = sci_ext_id; end
            lit("model_cycle_outputs", {19'd0, got}, {19'd0, e_ctl, e_pc, r_int_en, r_cause, r_epc});
        end
    end

    // ---------------------------------------------------------------
    // Directed stimulus with literal expectations.
    // ---------------------------------------------------------------
    task automatic nxt();
        @(posedge clk); #1;
        sci_pause_request = 0; sci_int = 0; sci_int_enable = 0; sci_int_disable = 0;
        sci_id_branch = 0; sci_ext_int = 0;
    endtask

    task automatic pause_len(input logic [3:0] cnt, input int exp_len, input string name);
        int n;
        n = 0;
        sci_pause_request = 1; sci_sched_type = 4'h1; sci_sched_count = cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!sco_stall) break;
            n++;
            nxt();
        end
        lit(name, 64'(n), 64'(exp_len));
        nxt();
    endtask

    initial begin : stim
        int k;
        // Reset held low
        @(negedge clk);
        lit("rst_int_en", 64'(sco_int_en), 64'd1);
        lit("rst_stall",  64'(sco_stall),  64'd0);
        lit("rst_branch", 64'(sco_branch), 64'd0);
        @(posedge clk); #1; rst = 1;
        @(negedge clk);
        lit("post_rst_cause",  64'(sco_cause), 64'h00);
        lit("post_rst_epc",    64'(sco_epc),   64'h0000);
        lit("post_rst_int_en", 64'(sco_int_en), 64'd1);
        nxt();

        // Stall lengths, including the 0-means-1 boundary
        pause_len(4'd3, 3, "pause_len_3");
        pause_len(4'd0, 1, "pause_len_0");
        pause_len(4'd1, 1, "pause_len_1");
        pause_len(4'd15, 15, "pause_len_15");

        // Software INT 4
        sci_int = 1; sci_int_id = 4'd4; sci_id_addr = 16'h0120;
        @(negedge clk);
        lit("int_branch", 64'(sco_branch), 64'd1);
        lit("int_new_pc", 64'(sco_new_pc), 64'h0008);
        lit("int_flush",  64'(sco_flush_id), 64'd1);
        nxt();
        @(negedge clk);
        lit("int_epc",    64'(sco_epc),   64'h0121);
        lit("int_cause",  64'(sco_cause), 64'h04);
        lit("int_int_en", 64'(sco_int_en), 64'd0);
        lit("trap_flush", 64'(sco_flush_id), 64'd1);
        lit("trap_branch", 64'(sco_branch), 64'd0);
        nxt();
        @(negedge clk);
        lit("after_trap_flush", 64'(sco_flush_id), 64'd0);
        nxt();

        // ERET
        sci_int = 1; sci_int_id = 4'hF;
        @(negedge clk);
        lit("eret_new_pc", 64'(sco_new_pc), 64'h0121);
        lit("eret_branch", 64'(sco_branch), 64'd1);
        nxt();
        @(negedge clk);
        lit("eret_int_en", 64'(sco_int_en), 64'd1);
        nxt();

        // External interrupt deferred by a branching ID instruction
        sci_ext_int = 1; sci_ext_id = 3'd2; sci_id_addr = 16'h0200;
        @(negedge clk);
        lit("ext_latch_cycle_branch", 64'(sco_branch), 64'd0);
        nxt();
        sci_ext_int = 1; sci_id_branch = 1;
        @(negedge clk);
        lit("ext_deferred_branch", 64'(sco_branch), 64'd0);
        nxt();
        @(negedge clk);
        lit("ext_taken_branch", 64'(sco_branch), 64'd1);
        lit("ext_taken_bubble", 64'(sco_bubble), 64'd1);
        lit("ext_taken_new_pc", 64'(sco_new_pc), 64'h0008);
        nxt();
        @(negedge clk);
        lit("ext_epc",   64'(sco_epc),   64'h0200);
        lit("ext_cause", 64'(sco_cause), 64'h82);
        nxt();
        sci_int_enable = 1;
        nxt();
        @(negedge clk);
        lit("mtih_enable", 64'(sco_int_en), 64'd1);
        nxt();

        // External pulse during PAUSE, int_en=1: taken on first RUN cycle
        sci_pause_request = 1; sci_sched_count = 4'd4; sci_id_addr = 16'h0300;
        nxt();
        sci_ext_int = 1; sci_ext_id = 3'd5;
        nxt();
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!sco_stall) break;
            k++;
            nxt();
        end
        lit("pause_ext_remaining_stall", 64'(k), 64'd2);
        lit("pause_ext_taken", 64'(sco_branch), 64'd1);
        nxt();
        @(negedge clk);
        lit("pause_ext_cause", 64'(sco_cause), 64'h85);
        lit("pause_ext_epc",   64'(sco_epc),   64'h0300);
        nxt();

        // MTIH: enable, then both asserted -> disable wins
        sci_int_enable = 1;
        nxt();
        sci_int_enable = 1; sci_int_disable = 1;
        nxt();
        @(negedge clk);
        lit("mtih_both_disable_wins", 64'(sco_int_en), 64'd0);
        nxt();

        // External pulse during PAUSE with int_en=0: held until enabled
        sci_pause_request = 1; sci_sched_count = 4'd2;
        nxt();
        sci_ext_int = 1; sci_ext_id = 3'd3;
        nxt();
        @(negedge clk);
        lit("held_pending_0", 64'(sco_branch), 64'd0);
        nxt();
        @(negedge clk);
        lit("held_pending_1", 64'(sco_branch), 64'd0);
        nxt();
        sci_int_enable = 1;
        @(negedge clk);
        lit("held_enable_cycle", 64'(sco_branch), 64'd0);
        nxt();
        @(negedge clk);
        lit("held_taken", 64'(sco_branch), 64'd1);
        nxt();
        @(negedge clk);
        lit("held_cause", 64'(sco_cause), 64'h83);
        nxt();

        // Pause outranks a same-cycle INT
        sci_pause_request = 1; sci_sched_count = 4'd1; sci_int = 1; sci_int_id = 4'd6;
        @(negedge clk);
        lit("prio_pause_stall",  64'(sco_stall),  64'd1);
        lit("prio_pause_branch", 64'(sco_branch), 64'd0);
        nxt();

        // EPC wraps from 16'hFFFF
        sci_int = 1; sci_int_id = 4'd7; sci_id_addr = 16'hFFFF;
        nxt();
        @(negedge clk);
        lit("wrap_epc", 64'(sco_epc), 64'h0000);
        nxt();
        sci_int = 1; sci_int_id = 4'hF;
        @(negedge clk);
        lit("wrap_eret_pc", 64'(sco_new_pc), 64'h0000);
        nxt();
        nxt();

        // Reset asserted mid-PAUSE
        sci_pause_request = 1; sci_sched_count = 4'd5;
        nxt();
        nxt();
        rst = 0;
        @(negedge clk);
        lit("midpause_rst_stall",  64'(sco_stall),  64'd0);
        lit("midpause_rst_int_en", 64'(sco_int_en), 64'd1);
        nxt();
        rst = 1;
        @(negedge clk);
        lit("midpause_release_stall", 64'(sco_stall), 64'd0);
        lit("midpause_release_cause", 64'(sco_cause), 64'h00);
        nxt();
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
